ysyx_25060170_ifu: RTL and testbench

Multi-cycle instruction fetch unit directly upstream of the decode stage. Owns the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel. It accepts the response and presents {pc, inst} to decode with a valid/ready handshake. Redirects from writeback (jump/branch target) flush any in-flight or held fetch.

---
 rtl/ysyx_25060170_ifu_pkg.sv | 19 +
 rtl/ysyx_25060170_ifu_if.sv | 41 ++++
 rtl/ysyx_25060170_ifu_perf.sv | 22 ++
 rtl/ysyx_25060170_ifu.sv | 127 ++++++++++++
 tb/tb_ysyx_25060170_ifu.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_ifu_pkg.sv
// Shared definitions for the ysyx_25060170 core: widths, reset vector and
// the fetch-unit state encoding.
package ysyx_25060170_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_if.sv
// Fetch-unit signal bundle: redirect input, instruction-memory request and
// response channels, and the decode-side handshake.
interface ysyx_25060170_ifu_if #(
  parameter int XLEN = ysyx_25060170_pkg::XLEN
);

  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_rsp_valid_i;
  logic [31:0]     imem_rsp_data_i;
  logic            imem_rsp_err_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     inst_o;
  logic            fetch_err_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i,
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    output inst_valid_o,
    input  inst_ready_i,
    output pc_o, inst_o, fetch_err_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i,
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  pc_o, inst_o, fetch_err_o
  );

endinterface

// File: rtl/ysyx_25060170_ifu_perf.sv
// Fetch performance counters: decode handshakes and memory stall cycles.
// Both free-running and wrapping; only built with YSYX_IFU_PERF_EN.
module ysyx_25060170_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_fire,
  input  logic        stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall)      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding imem request, redirect
// flush via a drop flag. Optional counters under YSYX_IFU_PERF_EN.
module ysyx_25060170_ifu #(
  parameter int                   XLEN     = ysyx_25060170_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = ysyx_25060170_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef YSYX_IFU_PERF_EN
  output logic [31:0]             perf_fetch_cnt_o,
  output logic [31:0]             perf_stall_cnt_o,
`endif
  ysyx_25060170_ifu_if.master     bus
);

  import ysyx_25060170_pkg::*;

  // state | meaning
  // S_REQ  | request for pc presented on imem
  // S_WAIT | request accepted, waiting for the response
  // S_OUT  | instruction held for decode
  ifu_state_e      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic            capture;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            err_q;
  logic            req_valid, inst_valid;
  logic            req_fire;

  assign req_fire = (state == S_REQ) && bus.imem_req_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      drop   <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
      if (capture) begin
        pc_q   <= pc;
        inst_q <= bus.imem_rsp_data_i;
        err_q  <= bus.imem_rsp_err_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    capture   = 1'b0;
    case (state)
      S_REQ: begin
        if (req_fire) begin
          state_nxt = S_WAIT;
          drop_nxt  = bus.redirect_valid_i;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          // A redirect arriving with the response kills it just like a stale drop.
          if (drop || bus.redirect_valid_i) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_OUT;
            capture   = 1'b1;
          end
        end else if (bus.redirect_valid_i) begin
          drop_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid_i) begin
          state_nxt = S_REQ;
        end else if (bus.inst_ready_i) begin
          state_nxt = S_REQ;
          pc_nxt    = seq_pc(pc);
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (bus.redirect_valid_i) pc_nxt = bus.redirect_pc_i;
  end

  always_comb begin
    req_valid  = 1'b0;
    inst_valid = 1'b0;
    if (!rst) begin
      req_valid  = (state == S_REQ);
      inst_valid = (state == S_OUT);
    end
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = pc;
  assign bus.inst_valid_o     = inst_valid;
  assign bus.pc_o             = pc_q;
  assign bus.inst_o           = inst_q;
  assign bus.fetch_err_o      = err_q;

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid_i |-> (state == S_WAIT));

`ifdef YSYX_IFU_PERF_EN
  logic perf_stall;
  assign perf_stall = ((state == S_REQ) && !bus.imem_req_ready_i) ||
                      ((state == S_WAIT) && !bus.imem_rsp_valid_i);

  ysyx_25060170_ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_fire     (inst_valid && bus.inst_ready_i),
    .stall          (perf_stall),
    .perf_fetch_cnt (perf_fetch_cnt_o),
    .perf_stall_cnt (perf_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed bench for ysyx_25060170_ifu: cycle-exact stimulus, one task per scenario.
module tb_ysyx_25060170_ifu;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ysyx_25060170_ifu_if #(.XLEN(32)) bus ();

`ifdef YSYX_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_25060170_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef YSYX_IFU_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt),
`endif
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.inst_ready_i     = 1'b0;
    repeat (3) tick();
    n_total++;
    if (bus.imem_req_valid_o !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid_o);
    else n_pass++;
    n_total++;
    if (bus.inst_valid_o !== 1'b0) $display("FAIL rst_inst_valid: got %b expected 0", bus.inst_valid_o);
    else n_pass++;
    n_total++;
    if ({bus.pc_o, bus.inst_o, bus.fetch_err_o} !== 65'd0)
      $display("FAIL rst_outputs: got pc %h inst %h err %b expected zeros", bus.pc_o, bus.inst_o, bus.fetch_err_o);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0000)
      $display("FAIL rst_release_req: got valid %b addr %h expected 1 80000000", bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
  endtask

  task automatic test_basic();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b0) $display("FAIL basic_wait_req: got %b expected 0", bus.imem_req_valid_o);
    else n_pass++;
    tick();
    n_total++;
    if (bus.inst_valid_o !== 1'b0) $display("FAIL basic_wait_inst: got %b expected 0", bus.inst_valid_o);
    else n_pass++;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0413;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h8000_0000 || bus.inst_o !== 32'h0000_0413 || bus.fetch_err_o !== 1'b0)
      $display("FAIL basic_out: got v %b pc %h inst %h err %b expected 1 80000000 00000413 0",
               bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.fetch_err_o);
    else n_pass++;
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0004 || bus.inst_valid_o !== 1'b0)
      $display("FAIL basic_next_req: got v %b addr %h iv %b expected 1 80000004 0",
               bus.imem_req_valid_o, bus.imem_req_addr_o, bus.inst_valid_o);
    else n_pass++;
  endtask

  task automatic test_decode_stall();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h00a0_0093;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'hffff_ffff;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h8000_0004 || bus.inst_o !== 32'h00a0_0093 || bus.imem_req_valid_o !== 1'b0)
        $display("FAIL stall_hold[%0d]: got v %b pc %h inst %h req %b expected 1 80000004 00a00093 0",
                 i, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imem_req_valid_o);
      else n_pass++;
      tick();
    end
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0008)
      $display("FAIL stall_release_req: got v %b addr %h expected 1 80000008", bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0100;
    tick();
    bus.redirect_valid_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b0) $display("FAIL rdw_still_wait: got %b expected 0", bus.imem_req_valid_o);
    else n_pass++;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'hdead_beef;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0100)
      $display("FAIL rdw_dropped: got iv %b req %b addr %h expected 0 1 80000100",
               bus.inst_valid_o, bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    // redirect together with the response
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0180;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h1234_5678;
    tick();
    bus.redirect_valid_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0180)
      $display("FAIL rdw_coincident: got iv %b req %b addr %h expected 0 1 80000180",
               bus.inst_valid_o, bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0011;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b1 || bus.pc_o !== 32'h8000_0180 || bus.inst_o !== 32'h0000_0011)
      $display("FAIL rdw_no_stale_drop: got v %b pc %h inst %h expected 1 80000180 00000011",
               bus.inst_valid_o, bus.pc_o, bus.inst_o);
    else n_pass++;
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
  endtask

  task automatic test_redirect_other();
    bus.imem_req_ready_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0200;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b0) $display("FAIL rdh_wait: got %b expected 0", bus.imem_req_valid_o);
    else n_pass++;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0033;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0200)
      $display("FAIL rdh_dropped: got iv %b req %b addr %h expected 0 1 80000200",
               bus.inst_valid_o, bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0300;
    tick();
    bus.redirect_valid_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0300)
      $display("FAIL rd_in_req: got v %b addr %h expected 1 80000300", bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0022;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    bus.inst_ready_i     = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0400;
    tick();
    bus.inst_ready_i     = 1'b0;
    bus.redirect_valid_i = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b0 || bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0400)
      $display("FAIL rd_in_out: got iv %b req %b addr %h expected 0 1 80000400",
               bus.inst_valid_o, bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
  endtask

  task automatic test_fetch_err();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0000;
    bus.imem_rsp_err_i   = 1'b1;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
    n_total++;
    if (bus.inst_valid_o !== 1'b1 || bus.fetch_err_o !== 1'b1 || bus.pc_o !== 32'h8000_0400)
      $display("FAIL err_out: got v %b err %b pc %h expected 1 1 80000400", bus.inst_valid_o, bus.fetch_err_o, bus.pc_o);
    else n_pass++;
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    n_total++;
    if (bus.imem_req_addr_o !== 32'h8000_0404) $display("FAIL err_next_req: got %h expected 80000404", bus.imem_req_addr_o);
    else n_pass++;
  endtask

  task automatic test_wrap_and_unaligned();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hffff_fffc;
    tick();
    bus.redirect_valid_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0010_0073;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    n_total++;
    if (bus.pc_o !== 32'hffff_fffc || bus.fetch_err_o !== 1'b0)
      $display("FAIL wrap_out: got pc %h err %b expected fffffffc 0", bus.pc_o, bus.fetch_err_o);
    else n_pass++;
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h0000_0000)
      $display("FAIL wrap_next_req: got v %b addr %h expected 1 00000000", bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0002;
    tick();
    bus.redirect_valid_i = 1'b0;
    n_total++;
    if (bus.imem_req_addr_o !== 32'h8000_0002) $display("FAIL unaligned_redirect: got %h expected 80000002", bus.imem_req_addr_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_req_ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.imem_req_valid_o !== 1'b0 || bus.inst_valid_o !== 1'b0 || bus.imem_req_addr_o !== 32'h8000_0000)
      $display("FAIL rstmid_async: got req %b iv %b addr %h expected 0 0 80000000",
               bus.imem_req_valid_o, bus.inst_valid_o, bus.imem_req_addr_o);
    else n_pass++;
    n_total++;
    if (bus.pc_o !== 32'h0 || bus.inst_o !== 32'h0 || bus.fetch_err_o !== 1'b0)
      $display("FAIL rstmid_outputs: got pc %h inst %h err %b expected zeros", bus.pc_o, bus.inst_o, bus.fetch_err_o);
    else n_pass++;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (bus.imem_req_valid_o !== 1'b1 || bus.imem_req_addr_o !== 32'h8000_0000)
      $display("FAIL rstmid_release: got v %b addr %h expected 1 80000000", bus.imem_req_valid_o, bus.imem_req_addr_o);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_other();
    test_fetch_err();
    test_wrap_and_unaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
